// File: rtl/ws2812_frame_sender_if.sv
// ws2812_frame_sender_if: control, pixel-read and strip-output signals between the frame buffer side and the sender.
interface ws2812_frame_sender_if #(
  parameter int MAX_LEDS = 64,
  parameter int BITS_PER_LED = 24
);
  localparam int AW = $clog2(MAX_LEDS + 1);
  logic go;
  logic auto_refresh;
  logic [AW-1:0] num_leds;
  logic pix_rd;
  logic [AW-1:0] pix_addr;
  logic [BITS_PER_LED-1:0] pix_data;
  logic ready;
  logic frame_done;
  logic data_out;
  modport master (
    output go, auto_refresh, num_leds, pix_data,
    input pix_rd, pix_addr, ready, frame_done, data_out
  );
  modport slave (
    input go, auto_refresh, num_leds, pix_data,
    output pix_rd, pix_addr, ready, frame_done, data_out
  );
endinterface

// File: rtl/ws2812_frame_sender.sv
// ws2812_frame_sender: streams a per-LED pixel frame from an external buffer to a WS2812B strip as MSB-first NZR.
// Each LED's successor is prefetched during its last bit so bit periods stay contiguous across the whole frame.
module ws2812_frame_sender #(
  parameter int MAX_LEDS = 64,
  parameter int BITS_PER_LED = 24,
  parameter int TBIT_CYC = 125,
  parameter int T0H_CYC = 40,
  parameter int T1H_CYC = 80,
  parameter int RESET_CYC = 30000
) (
  input logic clk,
  input logic rst_n,
  ws2812_frame_sender_if.slave bus
);
  localparam int AW = $clog2(MAX_LEDS + 1);
  localparam int TW = $clog2(TBIT_CYC);
  localparam int BW = $clog2(BITS_PER_LED);
  localparam int LW = $clog2(RESET_CYC + 1);
  localparam logic [AW-1:0] MAX_N = AW'(MAX_LEDS);
  typedef enum logic [1:0] {LATCH, IDLE, FETCH, SEND} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [AW-1:0] led_q, led_d, n_q, n_d, addr_q, addr_d, n_in;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [BITS_PER_LED-1:0] shift_q, shift_d, nxt_q, nxt_d;
  logic rd_q, rd_d, rd_dly_q, first_q, first_d, por_q, por_d;
  logic ready_q, ready_d, done_q, done_d, dout_q, dout_d;
  logic bit_end, led_end, frame_end, latch_end, start;
  assign n_in = (bus.num_leds > MAX_N) ? MAX_N : bus.num_leds;
  assign bit_end = tcnt_q == TW'(TBIT_CYC - 1);
  assign led_end = bit_end && bcnt_q == BW'(BITS_PER_LED - 1);
  assign frame_end = led_end && led_q == n_q - 1'b1;
  assign latch_end = lcnt_q == LW'(RESET_CYC - 1);
  always_comb begin
    state_d = state_q;
    tcnt_d = tcnt_q;
    bcnt_d = bcnt_q;
    led_d = led_q;
    n_d = n_q;
    addr_d = addr_q;
    lcnt_d = lcnt_q;
    shift_d = shift_q;
    nxt_d = nxt_q;
    por_d = por_q;
    ready_d = ready_q;
    rd_d = 1'b0;
    done_d = 1'b0;
    first_d = state_q == FETCH;
    start = 1'b0;
    unique case (state_q)
      LATCH: begin
        lcnt_d = lcnt_q + 1'b1;
        done_d = !por_q && lcnt_q == LW'(RESET_CYC - 2);
        if (latch_end) begin
          lcnt_d = '0;
          por_d = 1'b0;
          state_d = IDLE;
          ready_d = 1'b1;
          start = !por_q && bus.auto_refresh;
        end
      end
      IDLE: start = bus.go;
      FETCH: begin
        state_d = SEND;
        tcnt_d = '0;
        bcnt_d = '0;
        led_d = '0;
      end
      SEND: begin
        // first pixel arrives one clock into its first bit; its high phase is common to both symbols
        if (first_q) shift_d = bus.pix_data;
        tcnt_d = bit_end ? '0 : tcnt_q + 1'b1;
        if (bit_end) begin
          bcnt_d = led_end ? '0 : bcnt_q + 1'b1;
          shift_d = led_end ? nxt_q : shift_q << 1;
          led_d = led_end ? led_q + 1'b1 : led_q;
        end
        if (frame_end) begin
          state_d = LATCH;
          lcnt_d = '0;
        end
      end
    endcase
    if (start) begin
      n_d = n_in;
      ready_d = 1'b0;
      addr_d = '0;
      lcnt_d = '0;
      state_d = (n_in == '0) ? LATCH : FETCH;
      rd_d = n_in != '0;
    end
    if (state_d == SEND && tcnt_d == '0 && bcnt_d == BW'(BITS_PER_LED - 1) && led_d != n_q - 1'b1) begin
      rd_d = 1'b1;
      addr_d = led_d + 1'b1;
    end
    if (rd_dly_q && !first_q) nxt_d = bus.pix_data;
    dout_d = state_d == SEND && tcnt_d < (shift_d[BITS_PER_LED-1] ? TW'(T1H_CYC) : TW'(T0H_CYC));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LATCH;
      tcnt_q <= '0;
      bcnt_q <= '0;
      led_q <= '0;
      n_q <= '0;
      addr_q <= '0;
      lcnt_q <= '0;
      shift_q <= '0;
      nxt_q <= '0;
      rd_q <= 1'b0;
      rd_dly_q <= 1'b0;
      first_q <= 1'b0;
      por_q <= 1'b1;
      ready_q <= 1'b0;
      done_q <= 1'b0;
      dout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q <= tcnt_d;
      bcnt_q <= bcnt_d;
      led_q <= led_d;
      n_q <= n_d;
      addr_q <= addr_d;
      lcnt_q <= lcnt_d;
      shift_q <= shift_d;
      nxt_q <= nxt_d;
      rd_q <= rd_d;
      rd_dly_q <= rd_q;
      first_q <= first_d;
      por_q <= por_d;
      ready_q <= ready_d;
      done_q <= done_d;
      dout_q <= dout_d;
    end
  end
  assign bus.pix_rd = rd_q;
  assign bus.pix_addr = addr_q;
  assign bus.ready = ready_q;
  assign bus.frame_done = done_q;
  assign bus.data_out = dout_q;
endmodule

// File: tb/tb_ws2812_frame_sender.sv
// tb_ws2812_frame_sender: random frames checked against a waveform model built from the pixel words and bit timings.
module tb_ws2812_frame_sender;
  localparam int ML = 4, BPL = 24, TB = 10, T0 = 3, T1 = 7, RC = 50;
  localparam int AW = $clog2(ML + 1);
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ws2812_frame_sender_if #(.MAX_LEDS(ML), .BITS_PER_LED(BPL)) bus ();
  ws2812_frame_sender #(
    .MAX_LEDS(ML), .BITS_PER_LED(BPL), .TBIT_CYC(TB), .T0H_CYC(T0), .T1H_CYC(T1), .RESET_CYC(RC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  logic [BPL-1:0] mem [ML];
  bit exp_q[$];
  int rd_addrs[$];
  int n_cmp = 0, n_bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // frame buffer: answers each read one clock later, garbage otherwise
  initial begin
    logic r;
    logic [AW-1:0] a;
    bus.pix_data = '0;
    forever begin
      @(negedge clk);
      r = bus.pix_rd;
      a = bus.pix_addr;
      if (r) rd_addrs.push_back(int'(a));
      @(posedge clk);
      #1;
      bus.pix_data = (r && a < AW'(ML)) ? mem[a[1:0]] : BPL'($urandom);
    end
  end
  task automatic build_wave(input int n);
    exp_q.delete();
    for (int l = 0; l < n; l++)
      for (int b = BPL - 1; b >= 0; b--)
        for (int t = 0; t < TB; t++) exp_q.push_back(t < (mem[l][b] ? T1 : T0));
  endtask
  task automatic randomize_mem();
    for (int k = 0; k < ML; k++) mem[k] = BPL'($urandom);
  endtask
  task automatic start(input int nl, input bit scramble);
    @(negedge clk);
    bus.num_leds = AW'(nl);
    bus.go = 1'b1;
    @(posedge clk);
    #1;
    bus.go = 1'b0;
    if (scramble) bus.num_leds = AW'($urandom_range(0, 7));
  endtask
  task automatic por_check(input string tag);
    int bad = 0;
    for (int i = 1; i < RC; i++) begin
      @(negedge clk);
      if (bus.ready !== 1'b0 || bus.data_out !== 1'b0 || bus.frame_done !== 1'b0 || bus.pix_rd !== 1'b0) bad++;
    end
    check({tag, " por_quiet"}, bad, 0);
    @(negedge clk);
    check({tag, " por_ready"}, bus.ready, 1);
  endtask
  task automatic check_frame(input string tag, input int n, input bit auto_next, input int go_at);
    int bad_w = 0, bad_r = 0, bad_l = 0, bad_a = 0, dones = 0;
    bit exp_rd;
    build_wave(n);
    rd_addrs.delete();
    if (n > 0) begin
      @(negedge clk);
      check({tag, " fetch_rd"}, bus.pix_rd, 1);
      check({tag, " fetch_addr"}, bus.pix_addr, 0);
      check({tag, " fetch_dout"}, bus.data_out, 0);
      check({tag, " fetch_ready"}, bus.ready, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clk);
        bus.go = (i == go_at);
        exp_rd = (i % (BPL * TB) == (BPL - 1) * TB) && (i / (BPL * TB) < n - 1);
        if (bus.data_out !== exp_q[i]) bad_w++;
        if (bus.pix_rd !== exp_rd || (exp_rd && bus.pix_addr !== AW'(i / (BPL * TB) + 1)) || bus.ready !== 1'b0)
          bad_r++;
      end
      bus.go = 1'b0;
      check({tag, " wave_cycles_wrong"}, bad_w, 0);
      check({tag, " prefetch_cycles_wrong"}, bad_r, 0);
    end
    bus.auto_refresh = auto_next;
    for (int i = 0; i < RC; i++) begin
      @(negedge clk);
      if (bus.data_out !== 1'b0 || bus.pix_rd !== 1'b0 || bus.ready !== 1'b0) bad_l++;
      if (bus.frame_done === 1'b1) begin
        dones++;
        if (i != RC - 1) bad_l++;
      end
    end
    check({tag, " latch_quiet"}, bad_l, 0);
    check({tag, " frame_done_count"}, dones, 1);
    check({tag, " read_count"}, rd_addrs.size(), n);
    foreach (rd_addrs[k]) if (rd_addrs[k] != k) bad_a++;
    check({tag, " read_order"}, bad_a, 0);
    if (!auto_next) begin
      @(negedge clk);
      check({tag, " ready_after"}, bus.ready, 1);
    end
  endtask
  initial begin
    int bad, nl;
    bus.go = 1'b0;
    bus.auto_refresh = 1'b0;
    bus.num_leds = '0;
    repeat (3) @(negedge clk);
    check("rst data_out", bus.data_out, 0);
    check("rst ready", bus.ready, 0);
    check("rst pix_rd", bus.pix_rd, 0);
    check("rst pix_addr", bus.pix_addr, 0);
    check("rst frame_done", bus.frame_done, 0);
    rst_n = 1'b1;
    por_check("t1");
    mem[0] = 24'hFF0000;
    mem[1] = 24'h00000F;
    mem[2] = 24'h123456;
    mem[3] = 24'hABCDEF;
    start(2, 1'b1);
    check_frame("t2", 2, 1'b0, -1);
    start(0, 1'b1);
    check_frame("t3", 0, 1'b0, -1);
    randomize_mem();
    start(1, 1'b0);
    check_frame("t4a", 1, 1'b1, -1);
    check_frame("t4b", 1, 1'b1, -1);
    check_frame("t4c", 1, 1'b0, -1);
    randomize_mem();
    start(7, 1'b1);
    check_frame("t5", 4, 1'b0, 500);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.pix_rd !== 1'b0 || bus.ready !== 1'b1) bad++;
    end
    check("t5 go_not_queued", bad, 0);
    for (int r = 0; r < 5; r++) begin
      randomize_mem();
      nl = $urandom_range(0, 7);
      start(nl, 1'b1);
      check_frame($sformatf("rnd%0d", r), (nl > ML) ? ML : nl, 1'b0, $urandom_range(0, 199));
    end
    randomize_mem();
    start(2, 1'b1);
    @(negedge clk);
    repeat (BPL * TB + 5 * TB + 2) @(negedge clk);
    check("t6 mid_dout_high", bus.data_out, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6 async_dout", bus.data_out, 0);
    check("t6 async_ready", bus.ready, 0);
    check("t6 async_rd", bus.pix_rd, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    por_check("t6");
    randomize_mem();
    start(3, 1'b1);
    check_frame("t6 frame", 3, 1'b0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
